// File: rtl/irq_ctrl_pkg.sv
// Shared constants and helpers for the 8-source CPU interrupt controller.
package irq_ctrl_pkg;

  localparam int unsigned AddrW      = 16;
  localparam int unsigned DataW      = 8;
  localparam int unsigned MaxSources = 8;
  localparam int unsigned OfsW       = 3;
  localparam int unsigned WinBytes   = 6;

  localparam logic [OfsW-1:0] PEND_OFS   = 3'd0;
  localparam logic [OfsW-1:0] ENABLE_OFS = 3'd1;
  localparam logic [OfsW-1:0] ACTIVE_OFS = 3'd2;
  localparam logic [OfsW-1:0] VECTOR_OFS = 3'd3;
  localparam logic [OfsW-1:0] MODE_OFS   = 3'd4;
  localparam logic [OfsW-1:0] SWSET_OFS  = 3'd5;

  localparam logic [DataW-1:0] VEC_NONE = 8'h80;

  // Index of the lowest set bit, VEC_NONE when no bit is set.
  function automatic logic [DataW-1:0] lowest_set(input logic [MaxSources-1:0] v);
    logic [DataW-1:0] idx;
    idx = VEC_NONE;
    for (int i = MaxSources - 1; i >= 0; i--) begin
      if (v[i]) idx = DataW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser plus history flop for one interrupt source; flags a rising edge.
module irq_sync_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_c_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o  = s2_q;
  assign rise_c_o = s2_q & ~s3_q;

endmodule

// File: rtl/irq_ctrl_cpu.sv
// Memory-mapped 8-source interrupt controller driving the CPU's level IRQ input.
// Optional per-source edge/level MODE register enabled by IRQ_MODE_CFG_EN.
module irq_ctrl_cpu
  import irq_ctrl_pkg::*;
#(
  parameter logic [AddrW-1:0] BaseAddress = 16'h9500,
  parameter int unsigned      NumSources  = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [AddrW-1:0]      address_i,
  input  logic [DataW-1:0]      data_i,
  input  logic                  rd_wr_i,
  output logic [DataW-1:0]      data_o,
  input  logic [NumSources-1:0] src_i,
  output logic                  irq_o
);

  localparam logic [MaxSources-1:0] SrcMask = MaxSources'((1 << NumSources) - 1);

  logic [MaxSources-1:0] pend_q, pend_d;
  logic [MaxSources-1:0] enable_q, enable_d;
  logic [DataW-1:0]      data_q, data_d;
  logic                  irq_q, irq_d;
`ifdef IRQ_MODE_CFG_EN
  logic [MaxSources-1:0] mode_q, mode_d;
`endif

  logic [MaxSources-1:0] src_lvl, src_rise_c;
  logic [AddrW-1:0]      ofs_full_c;
  logic [OfsW-1:0]       ofs_c;
  logic                  in_win_c, wr_c;
  logic [MaxSources-1:0] wdata_c, active_c, set_c, clr_c, mode_rd_c;

  // Per-source synchronisers; unimplemented sources tie off to zero.
  for (genvar i = 0; i < NumSources; i++) begin : g_src
    irq_sync_edge u_sync (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .async_i  (src_i[i]),
      .level_o  (src_lvl[i]),
      .rise_c_o (src_rise_c[i])
    );
  end
  if (NumSources < MaxSources) begin : g_pad
    assign src_lvl[MaxSources-1:NumSources]    = '0;
    assign src_rise_c[MaxSources-1:NumSources] = '0;
  end

`ifndef IRQ_MODE_CFG_EN
  logic unused_src_lvl;
  assign unused_src_lvl = ^src_lvl;
`endif

  // Window decode: the unsigned distance from the base is below the window size.
  assign ofs_full_c = address_i - BaseAddress;
  assign in_win_c   = (ofs_full_c < AddrW'(WinBytes));
  assign ofs_c      = ofs_full_c[OfsW-1:0];
  assign wr_c       = rd_wr_i & in_win_c;

  always_comb begin
    wdata_c   = data_i & SrcMask;
    active_c  = pend_q & enable_q;
    enable_d  = enable_q;
    clr_c     = '0;
`ifdef IRQ_MODE_CFG_EN
    mode_d    = mode_q;
    mode_rd_c = mode_q;
    set_c     = (src_rise_c & mode_q) | (src_lvl & ~mode_q);
`else
    mode_rd_c = SrcMask;
    set_c     = src_rise_c;
`endif

    if (wr_c) begin
      case (ofs_c)
        PEND_OFS:   clr_c    = wdata_c;
        ENABLE_OFS: enable_d = wdata_c;
`ifdef IRQ_MODE_CFG_EN
        MODE_OFS:   mode_d   = wdata_c;
`endif
        SWSET_OFS:  set_c    = set_c | wdata_c;
        default:    ;
      endcase
    end

    // Any set source overrides a simultaneous write-1-to-clear.
    pend_d = (pend_q & ~clr_c) | set_c;
    irq_d  = |active_c;

    data_d = '0;
    if (in_win_c) begin
      case (ofs_c)
        PEND_OFS:   data_d = DataW'(pend_q);
        ENABLE_OFS: data_d = DataW'(enable_q);
        ACTIVE_OFS: data_d = DataW'(active_c);
        VECTOR_OFS: data_d = lowest_set(active_c);
        MODE_OFS:   data_d = DataW'(mode_rd_c);
        default:    data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend_q   <= '0;
      enable_q <= '0;
      data_q   <= '0;
      irq_q    <= 1'b0;
`ifdef IRQ_MODE_CFG_EN
      mode_q   <= SrcMask;
`endif
    end else begin
      pend_q   <= pend_d;
      enable_q <= enable_d;
      data_q   <= data_d;
      irq_q    <= irq_d;
`ifdef IRQ_MODE_CFG_EN
      mode_q   <= mode_d;
`endif
    end
  end

  assign data_o = data_q;
  assign irq_o  = irq_q;

endmodule
